// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller:
// FSM/grant encodings, default sizes and the address-width helper.
package rf_ctrl_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef enum logic {
        GR_WB  = 1'b0,
        GR_DBG = 1'b1
    } grant_e;

    function automatic int addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter for the write port. Index 0 is writeback and
// index 1 is debug. It also owns the last-grant register.
module rr_arbiter2
    import rf_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    input  state_e     state,
    output logic [1:0] ready
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    // Each ready looks only at the other requester's valid, so it never
    // combinationally depends on its own valid.
    always_comb begin
        ready = 2'b00;
        if (state == ST_RUN) begin
            ready[0] = !(valid[1] && (last_grant_q == GR_WB));
            ready[1] = !(valid[0] && (last_grant_q == GR_DBG));
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = (valid[0] && ready[0]) ? GR_WB : GR_DBG;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GR_DBG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port sequencer. After reset it clears r1..rN-1, then
// arbitrates the single write port between the writeback and debug requesters.
module regfile_write_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            dbg_valid,
    output logic            dbg_ready,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            init_done
);

    state_e          state_q,     state_d;
    logic [AW-1:0]   clr_idx_q,   clr_idx_d;
    logic            rf_we_q,     rf_we_d;
    logic [AW-1:0]   rf_waddr_q,  rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q,  rf_wdata_d;
    logic            init_done_q, init_done_d;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic            wb_fire;
    logic            dbg_fire;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    assign req_valid = {dbg_valid, wb_valid};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  (req_valid),
        .accept (accept),
        .state  (state_q),
        .ready  (req_ready)
    );

    assign wb_ready  = req_ready[0];
    assign dbg_ready = req_ready[1];
    assign wb_fire   = wb_valid  && req_ready[0];
    assign dbg_fire  = dbg_valid && req_ready[1];
    assign accept    = wb_fire || dbg_fire;
    assign sel_addr  = wb_fire ? wb_addr : dbg_addr;
    assign sel_data  = wb_fire ? wb_data : dbg_data;

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = clr_idx_q;
                rf_wdata_d = '0;
                clr_idx_d  = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(NREG - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // r0 writes still consume a grant but are never committed.
                if (accept) begin
                    rf_we_d    = (sel_addr != '0);
                    rf_waddr_d = sel_addr;
                    rf_wdata_d = sel_data;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= AW'(1);
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign init_done = init_done_q;

endmodule
